serial_block_rx: RTL
====================

SERIAL_BLOCK_RX -- requirements
Module: serial_block_rx

Interface
REQ-001 The block SHALL have the port CLOCK_50, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port KEY_0, input, 1 bit: reset, asynchronous and active-low (0 = reset).
REQ-003 The block SHALL have the port k_size_6144, input, 1 bit: block size, 0 = 1056 bits, 1 = 6144 bits; sampled only when start is accepted.
REQ-004 The block SHALL have the port start, input, 1 bit: begin receiving a block.
REQ-005 The block SHALL have the port bit_valid, input, 1 bit: ini/inpii carry a valid bit this cycle.
REQ-006 The block SHALL have the port ini, input, 1 bit: bit of the natural-order coder stream.
REQ-007 The block SHALL have the port inpii, input, 1 bit: bit of the interleaved coder stream.
REQ-008 The block SHALL have the port byte_i, output, 8 bits: packed byte from ini.
REQ-009 The block SHALL have the port byte_pii, output, 8 bits: packed byte from inpii.
REQ-010 The block SHALL have the port byte_valid, output, 1 bit: one-cycle strobe, byte_i/byte_pii/byte_index valid.
REQ-011 The block SHALL have the port byte_index, output, 10 bits: index of the current byte within the block (0..131 or 0..767).
REQ-012 The block SHALL have the port block_done, output, 1 bit: one-cycle strobe on the final byte of a block.
REQ-013 The block SHALL have the port busy, output, 1 bit: high while a block is being received.
REQ-014 The block SHALL have the port start_err, output, 1 bit: sticky flag, start seen while busy.

Function
REQ-015 The block SHALL implement exactly three states: IDLE, RECV, DONE.
REQ-016 In IDLE, start=1 SHALL latch k_size_6144, clear the bit counter (13 bits) and byte counter (10 bits), clear start_err, and enter RECV on the same edge.
REQ-017 In IDLE, bit_valid SHALL be ignored (no shift, no count).
REQ-018 In RECV, each edge with bit_valid=1 SHALL shift ini into the i shift register and inpii into the pii shift register, MSB first: the first bit of each byte lands in bit 7.
REQ-019 In RECV, each edge with bit_valid=1 SHALL increment the bit counter by 1.
REQ-020 Cycles with bit_valid=0 SHALL hold all registers; gaps of any length SHALL be tolerated.
REQ-021 On the edge that captures the 8th bit of a byte, the block SHALL register byte_i, byte_pii and byte_index (= byte counter before increment).
REQ-022 byte_valid SHALL be high for exactly the following cycle; latency is 1 cycle from the 8th bit.
REQ-023 On the 8th-bit edge, the byte counter SHALL increment and the 3-bit in-byte counter SHALL wrap 7->0.
REQ-024 The last bit of a block SHALL be bit count K-1, where K = 1056 or 6144 per the latched size.
REQ-025 On the edge capturing the last bit, the block SHALL enter DONE.
REQ-026 block_done SHALL assert in the same cycle as the final byte_valid.
REQ-027 DONE SHALL last exactly one cycle and then return to IDLE unconditionally; start in DONE SHALL be ignored without setting start_err.
REQ-028 busy SHALL be 1 in RECV and 0 in IDLE and DONE.
REQ-029 start=1 in RECV SHALL be ignored for reception and SHALL set start_err; start_err SHALL remain set until reset or the next accepted start.
REQ-030 start and bit_valid both high in IDLE SHALL start the block and discard that bit; the first counted bit is on the next bit_valid.
REQ-031 A change of k_size_6144 during RECV SHALL have no effect.
REQ-032 Counters SHALL never exceed K-1 or K/8-1; no partial byte SHALL ever be emitted.

Reset
REQ-033 While KEY_0=0, regardless of clock, the block SHALL be in IDLE with byte_i=0, byte_pii=0, byte_valid=0, byte_index=0, block_done=0, busy=0, start_err=0, and all counters and shift registers 0.
REQ-034 Reset asserted mid-block SHALL abandon the block; no byte_valid or block_done SHALL follow release.
REQ-035 After KEY_0 returns to 1, the first start SHALL be accepted on the next edge.

Verification
REQ-036 The bench SHALL check: K=1056, start, then 1056 contiguous bits with ini pattern 0xA5 repeated and inpii = ~ini -> 132 strobes, each byte_i=0xA5 and byte_pii=0x5A, byte_index 0..131, block_done only with index 131, busy falls after.
REQ-037 The bench SHALL check: K=6144, bit_valid toggling 1/0 -> 768 strobes, byte_index 767 carries block_done, each strobe exactly 1 cycle after its 8th valid bit.
REQ-038 The bench SHALL check: start pulsed at bit 500 of a 1056 block -> start_err=1, block still completes at 1056 bits; next accepted start clears start_err.
REQ-039 The bench SHALL check: KEY_0 pulled low at bit 3000 of a 6144 block -> all outputs 0 immediately, with no strobes after release until a new start.
REQ-040 The bench SHALL check: bit_valid=1 in IDLE without start -> no strobes; start together with bit_valid -> that bit is not counted (first byte formed from the next 8 bits).
REQ-041 The bench SHALL check: k_size_6144 toggled during a 1056 block -> still exactly 132 bytes.

Source files
------------

// File: rtl/serial_block_rx.sv
// Serial-to-byte receiver for two parallel coder bit streams (natural order and interleaved).
// Packs each stream MSB first into bytes over a block of 1056 or 6144 bits.
module serial_block_rx (
    input  logic       CLOCK_50,
    input  logic       KEY_0,
    input  logic       k_size_6144,
    input  logic       start,
    input  logic       bit_valid,
    input  logic       ini,
    input  logic       inpii,
    output logic [7:0] byte_i,
    output logic [7:0] byte_pii,
    output logic       byte_valid,
    output logic [9:0] byte_index,
    output logic       block_done,
    output logic       busy,
    output logic       start_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        k_big;
    logic [12:0] bit_cnt;
    logic [9:0]  byte_cnt;
    logic [2:0]  bit_in_byte;
    logic [7:0]  sh_i;
    logic [7:0]  sh_pii;

    logic        take_bit;
    logic        last_bit;
    logic        byte_end;
    logic        block_end;

    assign take_bit  = (state == RECV) && bit_valid;
    assign last_bit  = (bit_cnt == (k_big ? 13'd6143 : 13'd1055));
    assign byte_end  = take_bit && (bit_in_byte == 3'd7);
    assign block_end = take_bit && last_bit;
    assign busy      = (state == RECV);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK_50 or negedge KEY_0) begin
        if (!KEY_0) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RECV;
            RECV:    if (block_end) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge KEY_0) begin
        if (!KEY_0) begin
            k_big       <= 1'b0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            bit_in_byte <= '0;
            sh_i        <= '0;
            sh_pii      <= '0;
            byte_i      <= '0;
            byte_pii    <= '0;
            byte_index  <= '0;
            byte_valid  <= 1'b0;
            block_done  <= 1'b0;
            start_err   <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            block_done <= 1'b0;

            // A start that opens a block also swallows any bit presented with it.
            if (state == IDLE && start) begin
                k_big       <= k_size_6144;
                bit_cnt     <= '0;
                byte_cnt    <= '0;
                bit_in_byte <= '0;
                start_err   <= 1'b0;
            end

            if (state == RECV && start) begin
                start_err <= 1'b1;
            end

            if (take_bit) begin
                sh_i        <= {sh_i[6:0], ini};
                sh_pii      <= {sh_pii[6:0], inpii};
                bit_in_byte <= bit_in_byte + 3'd1;
                bit_cnt     <= last_bit ? 13'd0 : bit_cnt + 13'd1;

                if (byte_end) begin
                    byte_i     <= {sh_i[6:0], ini};
                    byte_pii   <= {sh_pii[6:0], inpii};
                    byte_index <= byte_cnt;
                    byte_valid <= 1'b1;
                    block_done <= last_bit;
                    byte_cnt   <= last_bit ? 10'd0 : byte_cnt + 10'd1;
                end
            end
        end
    end

endmodule
